wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the core: sits directly upstream of the register file and is the only block that drives its write port (`wr_en`, `rd_addr`, `rd_data`). Accepts one retiring instruction per cycle from execute over a valid/ready handshake. ALU results pass through a single register stage. Loads hold the stage until the data-memory response arrives, then sign- or zero-extend the selected byte/halfword/word before the write.

## Interface
- `DW`, 32, datapath width; only 32 is supported.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  execute presents a retiring instruction.
- `in_ready`  out  1  stage can accept; equals (state == IDLE).
- `in_wb_en`  in  1  instruction writes a destination register.
- `in_is_load`  in  1  instruction is a load; result comes from memory.
- `in_rd_addr`  in  5  destination register index.
- `in_funct3`  in  3  load width/sign code (ignored for non-loads).
- `in_alu_result`  in  DW  ALU result, or load byte address (bits [1:0] used).
- `mem_rsp_valid`  in  1  data-memory load response valid.
- `mem_rsp_data`  in  DW  aligned 32-bit word read from memory.
- `wr_en`  out  1  register-file write strobe.
- `rd_addr`  out  5  register-file write index.
- `rd_data`  out  DW  register-file write data.
- `instret`  out  64  retired-instruction count (present only with `WB_INSTRET_EN`).

## Operation
- States: IDLE, WAIT_LOAD. Accept = `in_valid && in_ready`.
- IDLE, accept non-load: next cycle `wr_en = in_wb_en && (in_rd_addr != 0)`, `rd_addr = in_rd_addr`, `rd_data = in_alu_result`; stay IDLE.
- IDLE, accept load: latch rd, wb_en, funct3, addr[1:0]; go WAIT_LOAD; `wr_en` 0 next cycle.
- WAIT_LOAD: `in_ready` = 0. On `mem_rsp_valid`: format data, next cycle assert write (same rd/wb_en gating), return to IDLE.
- Load formatting by latched funct3: 000 LB sign-extend byte addr[1:0]; 001 LH sign-extend halfword addr[1] (addr[0] ignored); 010 LW full word; 100 LBU zero-extend byte; 101 LHU zero-extend halfword; 011/110/111 write 0.
- `mem_rsp_valid` in IDLE is ignored (no write, no state change).
- rd = 0 or wb_en = 0: instruction still retires, `wr_en` stays 0; `rd_addr`/`rd_data` still update.
- Retire event: the cycle the write would be issued (`wr_en` register loaded), whether or not `wr_en` is 1.
- `wr_en` is a single-cycle pulse per retired instruction; never high two cycles for one instruction.

## Timing
- Reset values: state IDLE, `wr_en` 0, `rd_addr` 0, `rd_data` 0, `instret` 0; `in_ready` 1 during and after reset.
- Non-load latency: accept at edge N → `wr_en` high in cycle N+1. Full throughput, one per cycle back-to-back.
- Load latency: response at edge M → `wr_en` high in cycle M+1; response may arrive the cycle after accept (earliest) or any later cycle.
- `in_ready` drops the cycle after a load is accepted. It returns the cycle after the response, so a new instruction is accepted in the same cycle as the load write.
- `rd_addr`/`rd_data` are registered; register file sees them with `wr_en` in the same cycle.
- Reset asserted mid-WAIT_LOAD: pending load dropped, no write, IDLE on release; late response ignored.

## Configuration
- `WB_INSTRET_EN` defined: 64-bit `instret` port exists. Increments by 1 on each retire event and wraps from 2^64-1 to 0.
- Not defined: `instret` port and counter are absent; all other behaviour identical.

## Test plan
- Reset: hold `rst_n`=0 then release → `wr_en`=0, `rd_addr`=0, `rd_data`=0, `in_ready`=1, `instret`=0.
- Back-to-back ALU: accept rd=5/0x1234, then rd=6/0xFFFF0000, then rd=0/0x77 → `wr_en` pulses next cycles for x5, x6; third cycle `wr_en`=0; `instret`=3.
- Load formats: `mem_rsp_data`=0x80F1_7F82. LB addr 0 → 0xFFFF_FF82; LBU addr 3 → 0x0000_0080; LH addr 2 → 0xFFFF_80F1; LHU addr 0 → 0x0000_7F82; LW → 0x80F1_7F82.
- Load stall: accept LW rd=7, hold `in_valid` with ALU op for 4 cycles before response → `in_ready`=0 throughout, no write. Response → x7 written next cycle, then ALU op accepted and written one cycle later.
- Stray/reset: `mem_rsp_valid` in IDLE → no write. Reset during WAIT_LOAD, then response → no write, state IDLE.
- Counter wrap (`WB_INSTRET_EN`): force `instret` to 0xFFFF_FFFF_FFFF_FFFF, retire one ALU op → `instret`=0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results and formatted load data onto the register-file write port.
// Optional 64-bit retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_wb_en,
    input  logic          in_is_load,
    input  logic [4:0]    in_rd_addr,
    input  logic [2:0]    in_funct3,
    input  logic [DW-1:0] in_alu_result,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_data,
    output logic          wr_en,
    output logic [4:0]    rd_addr,
    output logic [DW-1:0] rd_data
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]   instret
`endif
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t        state_reg;
    logic [4:0]    ld_rd_reg;
    logic          ld_wb_en_reg;
    logic [2:0]    ld_funct3_reg;
    logic [1:0]    ld_addr_reg;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [DW-1:0] load_data;

    assign in_ready = (state_reg == IDLE);

    // Byte/halfword lane selection and extension of the returned memory word.
    always_comb begin
        sel_byte  = 8'h00;
        sel_half  = 16'h0000;
        load_data = '0;
        case (ld_addr_reg)
            2'd0:    sel_byte = mem_rsp_data[7:0];
            2'd1:    sel_byte = mem_rsp_data[15:8];
            2'd2:    sel_byte = mem_rsp_data[23:16];
            default: sel_byte = mem_rsp_data[31:24];
        endcase
        sel_half = ld_addr_reg[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        case (ld_funct3_reg)
            3'b000:  load_data = {{(DW-8){sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{(DW-16){sel_half[15]}}, sel_half};
            3'b010:  load_data = mem_rsp_data;
            3'b100:  load_data = {{(DW-8){1'b0}}, sel_byte};
            3'b101:  load_data = {{(DW-16){1'b0}}, sel_half};
            default: load_data = '0;
        endcase
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_reg;
    logic        retire;

    assign retire  = (state_reg == IDLE) ? (in_valid && !in_is_load) : mem_rsp_valid;
    assign instret = instret_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_reg <= '0;
        end else if (retire) begin
            instret_reg <= instret_reg + 64'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_en         <= 1'b0;
            rd_addr       <= '0;
            rd_data       <= '0;
            ld_rd_reg     <= '0;
            ld_wb_en_reg  <= 1'b0;
            ld_funct3_reg <= '0;
            ld_addr_reg   <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (in_is_load) begin
                            ld_rd_reg     <= in_rd_addr;
                            ld_wb_en_reg  <= in_wb_en;
                            ld_funct3_reg <= in_funct3;
                            ld_addr_reg   <= in_alu_result[1:0];
                            state_reg     <= WAIT_LOAD;
                        end else begin
                            wr_en   <= in_wb_en && (in_rd_addr != 5'd0);
                            rd_addr <= in_rd_addr;
                            rd_data <= in_alu_result;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (mem_rsp_valid) begin
                        wr_en     <= ld_wb_en_reg && (ld_rd_reg != 5'd0);
                        rd_addr   <= ld_rd_reg;
                        rd_data   <= load_data;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic against a transaction-level model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_wb_en;
    logic        in_is_load;
    logic [4:0]  in_rd_addr;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    always #5 clk = ~clk;

    wb_stage #(.DW(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_wb_en(in_wb_en),
        .in_is_load(in_is_load),
        .in_rd_addr(in_rd_addr),
        .in_funct3(in_funct3),
        .in_alu_result(in_alu_result),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .wr_en(wr_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
`ifdef WB_INSTRET_EN
        ,
        .instret(instret)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding load (if any) and what the register file should see.
    bit          m_busy;
    logic [4:0]  m_rd;
    bit          m_wb;
    logic [2:0]  m_f3;
    int          m_addr;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [63:0] m_instret;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [2:0] f3, input int addr);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * addr)) & 32'hFF;
        h = (word >> (16 * (addr / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b010:  return word;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic set_idle();
        in_valid      = 1'b0;
        in_wb_en      = 1'b0;
        in_is_load    = 1'b0;
        in_rd_addr    = 5'd0;
        in_funct3     = 3'd0;
        in_alu_result = 32'h0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
    endtask

    // One clock: predict from current inputs, advance, compare.
    task automatic cycle();
        bit e_wr;
        bit retire;
        e_wr   = 1'b0;
        retire = 1'b0;
        check("in_ready", in_ready, m_busy ? 1'b0 : 1'b1);
        if (!m_busy) begin
            if (in_valid) begin
                if (in_is_load) begin
                    m_busy = 1'b1;
                    m_rd   = in_rd_addr;
                    m_wb   = in_wb_en;
                    m_f3   = in_funct3;
                    m_addr = int'(in_alu_result[1:0]);
                end else begin
                    retire = 1'b1;
                    e_wr   = in_wb_en && (in_rd_addr != 0);
                    e_rd   = in_rd_addr;
                    e_data = in_alu_result;
                end
            end
        end else if (mem_rsp_valid) begin
            retire = 1'b1;
            m_busy = 1'b0;
            e_wr   = m_wb && (m_rd != 0);
            e_rd   = m_rd;
            e_data = load_fmt(mem_rsp_data, m_f3, m_addr);
        end
        if (retire) m_instret = m_instret + 64'd1;
        @(posedge clk);
        #1;
        check("wr_en", wr_en, e_wr);
        check("rd_addr", rd_addr, e_rd);
        check("rd_data", rd_data, e_data);
`ifdef WB_INSTRET_EN
        check("instret", instret, m_instret);
`endif
        if (retire) $display("retire rd=%0d data=%08h wr_en=%0b", e_rd, e_data, e_wr);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        m_busy    = 1'b0;
        e_rd      = 5'd0;
        e_data    = 32'h0;
        m_instret = 64'd0;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_rd_addr", rd_addr, 5'd0);
        check("rst_rd_data", rd_data, 32'h0);
`ifdef WB_INSTRET_EN
        check("rst_instret", instret, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val);
        in_valid      = 1'b1;
        in_is_load    = 1'b0;
        in_wb_en      = 1'b1;
        in_rd_addr    = rd;
        in_alu_result = val;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] addr);
        in_valid      = 1'b1;
        in_is_load    = 1'b1;
        in_wb_en      = 1'b1;
        in_rd_addr    = rd;
        in_funct3     = f3;
        in_alu_result = {$urandom_range(0, 1023), 20'h0, 10'h0} | {30'h0, addr};
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] addr, input logic [31:0] exp);
        set_idle();
        drive_load(5'd3, f3, addr);
        cycle();
        set_idle();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h80F1_7F82;
        cycle();
        check(tag, rd_data, exp);
        set_idle();
    endtask

    initial begin
        set_idle();
        m_rd   = 5'd0;
        m_wb   = 1'b0;
        m_f3   = 3'd0;
        m_addr = 0;
        do_reset();

        // Back-to-back ALU ops, third targets x0.
        drive_alu(5'd5, 32'h0000_1234);
        cycle();
        check("b2b_x5", {wr_en, rd_addr}, {1'b1, 5'd5});
        drive_alu(5'd6, 32'hFFFF_0000);
        cycle();
        check("b2b_x6", rd_data, 32'hFFFF_0000);
        drive_alu(5'd0, 32'h0000_0077);
        cycle();
        check("b2b_x0_no_write", wr_en, 1'b0);
`ifdef WB_INSTRET_EN
        check("b2b_instret", instret, 64'd3);
`endif
        set_idle();
        cycle();

        // Load formatting.
        do_load("LB_a0", 3'b000, 2'd0, 32'hFFFF_FF82);
        do_load("LBU_a3", 3'b100, 2'd3, 32'h0000_0080);
        do_load("LH_a2", 3'b001, 2'd2, 32'hFFFF_80F1);
        do_load("LHU_a0", 3'b101, 2'd0, 32'h0000_7F82);
        do_load("LW", 3'b010, 2'd0, 32'h80F1_7F82);
        do_load("LH_a3", 3'b001, 2'd3, 32'hFFFF_80F1);
        do_load("f3_011", 3'b011, 2'd0, 32'h0);

        // Load stall with an ALU op waiting behind it.
        drive_load(5'd7, 3'b010, 2'd0);
        cycle();
        drive_alu(5'd9, 32'hCAFE_0009);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_ready", in_ready, 1'b0);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1357_9BDF;
        cycle();
        check("stall_x7", {wr_en, rd_addr, rd_data}, {1'b1, 5'd7, 32'h1357_9BDF});
        mem_rsp_valid = 1'b0;
        cycle();
        check("stall_x9", {wr_en, rd_addr, rd_data}, {1'b1, 5'd9, 32'hCAFE_0009});
        set_idle();

        // Stray response while idle.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        cycle();
        check("stray_no_write", wr_en, 1'b0);
        set_idle();

        // Reset while a load is outstanding, then a late response.
        drive_load(5'd12, 3'b010, 2'd0);
        cycle();
        set_idle();
        cycle();
        do_reset();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_2222;
        cycle();
        check("late_rsp_no_write", wr_en, 1'b0);
        check("late_rsp_idle", in_ready, 1'b1);
        set_idle();

`ifdef WB_INSTRET_EN
        // Counter wrap.
        force dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_reg;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        drive_alu(5'd1, 32'h1);
        cycle();
        check("instret_wrap", instret, 64'd0);
        set_idle();
`endif

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_is_load    = ($urandom_range(0, 2) == 0);
            in_wb_en      = ($urandom_range(0, 7) != 0);
            in_rd_addr    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            in_funct3     = 3'($urandom);
            in_alu_result = $urandom;
            mem_rsp_valid = ($urandom_range(0, 1) == 1);
            mem_rsp_data  = $urandom;
            cycle();
        end
        set_idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
